// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and operand-use helpers shared by the decode stage.
package mips_isa_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int INS_W_DEF  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int FN_MSB  = 5;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic uses_rs(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_SW, OP_BEQ};
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use detection and fetch redirect selection.
module hazard_detect_unit
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              load_use,
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc
);

    logic rs_conflict;
    logic rt_conflict;
    logic j_id;

    always_comb begin
        rs_conflict = uses_rs(id_opcode) && (ex_rt == id_rs);
        rt_conflict = uses_rt(id_opcode) && (ex_rt == id_rt);
        load_use    = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid
                      && (rs_conflict || rt_conflict);
        j_id        = id_valid && (id_opcode == OP_J);

        // A taken branch flushes both stages, so it overrides any hold.
        stall      = load_use && !ex_branch_taken;
        stall_pm   = stall;
        pc_mux_sel = ex_branch_taken || j_id;

        jmp_loc = '0;
        if (ex_branch_taken) begin
            jmp_loc = ex_branch_target;
        end else if (j_id) begin
            jmp_loc = id_jump_target;
        end
    end

endmodule

// File: rtl/instruction_decode_block.sv
// IF/ID and ID/EX pipeline registers with field decode, hazard stall and redirect.
module instruction_decode_block
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INS_W-1:0]  ins,
    input  logic [ADDR_W-1:0] current_address,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              pc_mux_sel,
    output logic              stall,
    output logic              stall_pm,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [31:0]       ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src
);

    logic [INS_W-1:0]  id_ins_q, id_ins_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic              id_valid_q, id_valid_d;

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
    logic [5:0]        ex_opcode_q, ex_opcode_d;
    logic [5:0]        ex_funct_q, ex_funct_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_dest_q, ex_dest_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic              ex_mem_write_q, ex_mem_write_d;
    logic              ex_alu_src_q, ex_alu_src_d;

    logic [5:0]        id_opcode;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              load_use;
    logic              hz_stall;
    logic              hz_stall_pm;
    logic              hz_pc_mux_sel;
    logic [ADDR_W-1:0] hz_jmp_loc;

    assign id_opcode = id_ins_q[OPC_MSB:OPC_LSB];
    assign id_rs     = id_ins_q[RS_MSB:RS_LSB];
    assign id_rt     = id_ins_q[RT_MSB:RT_LSB];
    assign id_rd     = id_ins_q[RD_MSB:RD_LSB];

    hazard_detect_unit #(
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .id_valid         (id_valid_q),
        .id_opcode        (id_opcode),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_jump_target   (id_ins_q[ADDR_W-1:0]),
        .ex_valid         (ex_valid_q),
        .ex_mem_read      (ex_mem_read_q),
        .ex_rt            (ex_rt_q),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .load_use         (load_use),
        .stall            (hz_stall),
        .stall_pm         (hz_stall_pm),
        .pc_mux_sel       (hz_pc_mux_sel),
        .jmp_loc          (hz_jmp_loc)
    );

    // Redirect depends on a live EX input, so it must be masked while reset is held.
    assign pc_mux_sel = reset && hz_pc_mux_sel;
    assign jmp_loc    = reset ? hz_jmp_loc : '0;
    assign stall      = reset && hz_stall;
    assign stall_pm   = reset && hz_stall_pm;

    always_comb begin
        id_ins_d   = id_ins_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (!hz_stall) begin
            id_ins_d   = ins;
            id_pc_d    = current_address;
            id_valid_d = !hz_pc_mux_sel;
        end
    end

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_pc_d        = '0;
        ex_opcode_d    = '0;
        ex_funct_d     = '0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_dest_d      = '0;
        ex_imm_d       = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_alu_src_d   = 1'b0;
        if (!(ex_branch_taken || load_use || !id_valid_q)) begin
            ex_valid_d  = 1'b1;
            ex_pc_d     = id_pc_q;
            ex_opcode_d = id_opcode;
            ex_funct_d  = id_ins_q[FN_MSB:0];
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
            ex_imm_d    = {{16{id_ins_q[IMM_MSB]}}, id_ins_q[IMM_MSB:0]};
            unique case (id_opcode)
                OP_RTYPE: begin
                    ex_dest_d      = id_rd;
                    ex_reg_write_d = 1'b1;
                end
                OP_ADDI: begin
                    ex_dest_d      = id_rt;
                    ex_reg_write_d = 1'b1;
                    ex_alu_src_d   = 1'b1;
                end
                OP_LW: begin
                    ex_dest_d      = id_rt;
                    ex_reg_write_d = 1'b1;
                    ex_mem_read_d  = 1'b1;
                    ex_alu_src_d   = 1'b1;
                end
                OP_SW: begin
                    ex_mem_write_d = 1'b1;
                    ex_alu_src_d   = 1'b1;
                end
                default: begin
                end
            endcase
            // Writes to $0 are discarded here so an all-zero word decodes as a NOP.
            if (ex_dest_d == 5'd0) begin
                ex_reg_write_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ins_q       <= '0;
            id_pc_q        <= '0;
            id_valid_q     <= 1'b0;
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_opcode_q    <= '0;
            ex_funct_q     <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_imm_q       <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_alu_src_q   <= 1'b0;
        end else begin
            id_ins_q       <= id_ins_d;
            id_pc_q        <= id_pc_d;
            id_valid_q     <= id_valid_d;
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_funct_q     <= ex_funct_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_imm_q       <= ex_imm_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_alu_src_q   <= ex_alu_src_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_funct     = ex_funct_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_imm       = ex_imm_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_alu_src   = ex_alu_src_q;

endmodule

// File: tb/tb_instruction_decode_block.sv
// Scoreboard bench: an instruction-level pipeline model predicts each cycle's outputs.
module tb_instruction_decode_block;

    typedef struct packed {
        logic        v;
        logic [15:0] pc;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
    } ex_t;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [15:0] pc;
    } id_t;

    typedef struct {
        ex_t         ex;
        logic        stall;
        logic        sel;
        logic [15:0] jl;
        int          cyc;
    } exp_rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [15:0] current_address;
    logic        ex_branch_taken;
    logic [15:0] ex_branch_target;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel, stall, stall_pm;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [31:0] ex_imm;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;

    ex_t      dut_ex;
    id_t      m_id;
    ex_t      m_ex;
    exp_rec_t exp_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    int       cycle_no = 0;

    instruction_decode_block dut (
        .clk              (clk),
        .reset            (reset),
        .ins              (ins),
        .current_address  (current_address),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .jmp_loc          (jmp_loc),
        .pc_mux_sel       (pc_mux_sel),
        .stall            (stall),
        .stall_pm         (stall_pm),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_opcode        (ex_opcode),
        .ex_funct         (ex_funct),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_dest          (ex_dest),
        .ex_imm           (ex_imm),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_alu_src       (ex_alu_src)
    );

    always #5 clk = ~clk;

    assign dut_ex = {ex_valid, ex_pc, ex_opcode, ex_funct, ex_rs, ex_rt, ex_dest,
                     ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src};

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_no, act, exp);
        end
    endtask

    function automatic ex_t model_decode(input logic [31:0] w, input logic [15:0] pc);
        ex_t e;
        e      = '0;
        e.v    = 1'b1;
        e.pc   = pc;
        e.op   = w[31:26];
        e.fn   = w[5:0];
        e.rs   = w[25:21];
        e.rt   = w[20:16];
        e.imm  = 32'($signed(w[15:0]));
        case (e.op)
            6'h00: begin e.dest = w[15:11]; e.rw = 1'b1; end
            6'h08: begin e.dest = e.rt; e.rw = 1'b1; e.as = 1'b1; end
            6'h23: begin e.dest = e.rt; e.rw = 1'b1; e.mr = 1'b1; e.as = 1'b1; end
            6'h2B: begin e.mw = 1'b1; e.as = 1'b1; end
            default: ;
        endcase
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op;
        logic       rs_used, rt_used;
        op      = w[31:26];
        rs_used = (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
        rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return (rs_used && w[25:21] == r) || (rt_used && w[20:16] == r);
    endfunction

    // Predict the current cycle's outputs from model state and inputs, then advance the model.
    task automatic drive(input logic [31:0] w, input logic [15:0] pc, input logic br, input logic [15:0] tgt);
        exp_rec_t r;
        logic     lu, hold;
        ins              = w;
        current_address  = pc;
        ex_branch_taken  = br;
        ex_branch_target = tgt;
        #1;
        lu = m_ex.v && m_ex.mr && (m_ex.rt != 5'd0) && m_id.v && reads_reg(m_id.ins, m_ex.rt);
        hold = lu && !br;
        r.ex    = m_ex;
        r.stall = hold;
        r.cyc   = cycle_no;
        if (br) begin
            r.sel = 1'b1;
            r.jl  = tgt;
        end else if (m_id.v && m_id.ins[31:26] == 6'h02) begin
            r.sel = 1'b1;
            r.jl  = m_id.ins[15:0];
        end else begin
            r.sel = 1'b0;
            r.jl  = 16'h0;
        end
        exp_q.push_back(r);
        if (hold) begin
            m_ex = '0;
        end else begin
            m_ex = (br || !m_id.v) ? ex_t'('0) : model_decode(m_id.ins, m_id.pc);
            m_id = '{v: !r.sel, ins: w, pc: pc};
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] w, input logic [15:0] pc,
                                  input logic br = 1'b0, input logic [15:0] tgt = 16'h0);
        @(negedge clk);
        drive(w, pc, br, tgt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_stall"}, 96'(stall), 96'(0));
        check_output({tag, "_stall_pm"}, 96'(stall_pm), 96'(0));
        check_output({tag, "_pc_mux_sel"}, 96'(pc_mux_sel), 96'(0));
        check_output({tag, "_jmp_loc"}, 96'(jmp_loc), 96'(0));
        check_output({tag, "_ex_fields"}, 96'(dut_ex), 96'(0));
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops [8];
        logic [5:0] op;
        logic [31:0] w;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0F, 6'h23};
        op  = ops[$urandom_range(0, 7)];
        w   = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        if (op == 6'h00) w[15:11] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin : monitor
        exp_rec_t r;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check_output("ex_fields", 96'(dut_ex), 96'(r.ex));
                check_output("stall", 96'(stall), 96'(r.stall));
                check_output("stall_pm", 96'(stall_pm), 96'(r.stall));
                check_output("pc_mux_sel", 96'(pc_mux_sel), 96'(r.sel));
                check_output("jmp_loc", 96'(jmp_loc), 96'(r.jl));
            end
        end
    end

    always @(posedge clk) cycle_no <= cycle_no + 1;

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        m_id = '0;
        m_ex = '0;
        reset = 1'b0;
        ins = 32'hDEAD_BEEF;
        current_address = 16'h1234;
        ex_branch_taken = 1'b1;
        ex_branch_target = 16'h5555;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset_hold");

        @(negedge clk);
        reset = 1'b1;
        drive(32'h0022_1820, 16'h0000, 1'b0, 16'h0);
        apply_stimulus(32'h0, 16'h0001);
        apply_stimulus(32'h0, 16'h0002);

        apply_stimulus(32'h8C25_0004, 16'h0000);
        apply_stimulus(32'h00A2_3020, 16'h0001);
        apply_stimulus(32'h0, 16'h0002);
        apply_stimulus(32'h0, 16'h0003);
        apply_stimulus(32'h0, 16'h0004);

        apply_stimulus(32'h8C25_0004, 16'h0000);
        apply_stimulus(32'h00E2_3020, 16'h0001);
        apply_stimulus(32'h0, 16'h0002);
        apply_stimulus(32'h0, 16'h0003);

        apply_stimulus(32'h0800_0008, 16'h0004);
        apply_stimulus(32'h0022_1820, 16'h0005);
        apply_stimulus(32'h0, 16'h0008);
        apply_stimulus(32'h0, 16'h0009);

        apply_stimulus(32'h8C25_0004, 16'h0000);
        apply_stimulus(32'h00A2_3020, 16'h0001);
        apply_stimulus(32'h0, 16'h0002, 1'b1, 16'h0020);
        apply_stimulus(32'h0, 16'h0020);
        apply_stimulus(32'h0, 16'h0021);

        apply_stimulus(32'h8C25_0004, 16'h0000);
        apply_stimulus(32'h00A2_3020, 16'h0001);
        @(negedge clk);
        ins = 32'h0;
        ex_branch_taken = 1'b1;
        ex_branch_target = 16'h00F0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_id = '0;
        m_ex = '0;
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0022_1820, 16'h0010, 1'b0, 16'h0);
        apply_stimulus(32'h2043_0005, 16'h0011);
        apply_stimulus(32'h0, 16'h0012);
        apply_stimulus(32'h0, 16'h0013);

        for (int i = 0; i < 500; i++) begin
            apply_stimulus(rand_ins(), 16'(i + 16'h0100), ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        @(negedge clk);
        #6;
        check_output("queue_drained", 96'(exp_q.size()), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
